iq_nibble_unpack: RTL and testbench
===================================

// Module: iq_nibble_unpack
// PURPOSE
//  Receive-side inverse of the 4-bit IQ packer: takes one 32-bit word carrying four packed
//  8-bit symbols ({I nibble, Q nibble}) and emits four 32-bit samples ({I16, Q16}), one per handshake.
//  Sits in the QPSK RFNoC chain after the compressed-stream transport and before the demodulator.
//  Rate is 1 input word : 4 output samples, with AXI-Stream flow control on both sides.
// PARAMETERS
//  WIDTH      32   stream data width; only 32 is supported (elaboration error otherwise)
//  NSUB       4    symbols per input word; fixed localparam, not overridable
// PORTS
//  clk        in   1      single clock domain
//  reset      in   1      synchronous, active-high
//  i_tdata    in   32     packed word: four bytes, each {Is,Ib[2:0],Qs,Qb[2:0]}
//  i_tlast    in   1      last word of packet
//  i_tvalid   in   1      input valid
//  i_tready   out  1      input ready
//  o_tdata    out  32     {I[15:0], Q[15:0]} expanded sample
//  o_tlast    out  1      last sample of packet
//  o_tvalid   out  1      output valid
//  o_tready   in   1      output ready
// BEHAVIOUR
//  - Reset: hold register=0, sub_cnt=0, state IDLE; o_tvalid=0, o_tlast=0, o_tdata=0, i_tready=1.
//  - Lane order (must match the packer): sample0=[23:16], sample1=[31:24], sample2=[7:0], sample3=[15:8].
//  - Expansion per nibble {s,b[2:0]}: v16 = {{4{s}}, b[2:0], 9'b0} (two's complement, bits 14:12 = sign).
//  - FSM IDLE: i_tready=1; on i_tvalid&i_tready latch word+tlast, sub_cnt<=0, go EMIT.
//  - FSM EMIT: o_tvalid=1; o_tdata = expand(lane[sub_cnt]) from hold reg; on o_tvalid&o_tready
//    sub_cnt++ ; at sub_cnt==3 the word is exhausted.
//  - Latency: first sample valid 1 cycle after input accept. No bubbles: i_tready is also 1 in EMIT
//    when sub_cnt==3 && o_tready, so the next word loads in the same cycle the last sample leaves
//    (stay EMIT, sub_cnt<=0). Otherwise, on exhaustion, return to IDLE.
//  - i_tready=0 in EMIT unless the above holds; input data is never dropped or overwritten.
//  - o_tlast = latched tlast & (sub_cnt==3); never asserted on samples 0..2.
//  - o_tvalid low-to-high only after accept; once high it holds with stable o_tdata/o_tlast until taken.
//  - Reset mid-word: remaining samples are discarded; state returns to the reset values above.
//  - Simultaneous i_tvalid with no room: input stalls; the held word is unaffected.
// CONFIGURATION
//  - IQ_UNPACK_ROUND_MID_EN defined: each expanded value gets +16'h0100 (mid-point of the 9 discarded
//    LSBs), giving v16 = {{4{s}}, b[2:0], 9'h100}; this reduces dequantisation bias.
//  - Not defined: the 9 LSBs are zero-filled exactly as listed above.
// STRUCTURE
//  - Package iq_nibble_pkg: LANE_LSB[0:3] = {16,24,0,8}, NSUB=4, NIB_W=4, DISCARD_LSB=9,
//    ROUND_OFS=16'h0100, FSM state enum {IDLE, EMIT}.
//  - Sub-module iq_nibble_expand: combinational, 8-bit byte -> 32-bit {I16,Q16}; contains the
//    IQ_UNPACK_ROUND_MID_EN ifdef. The top level holds the FSM, sub_cnt, hold register and handshakes.
// TESTING
//  - Word 0x12345678, o_tready=1 -> 0x06000800, 0x02000400, 0x0E00F000, 0x0A000C00 on 4 consecutive cycles.
//  - Same word with IQ_UNPACK_ROUND_MID_EN -> 0x07000900, 0x03000500, 0x0F00F100, 0x0B000D00.
//  - Byte 0xFF in all lanes -> 0xFE00FE00 x4; byte 0x88 -> 0xF000F000 (negative full-scale).
//  - Back-to-back words with i_tvalid=1 and o_tready=1 -> o_tvalid is continuously high for 8 cycles;
//    i_tready pulses on the 4th sample.
//  - Random o_tready (50%) over 64 words with i_tlast every 8th -> sample order matches the model;
//    o_tlast fires only on the 4th sample of each tlast word; no loss or duplication.
//  - Reset asserted after 2 of 4 samples -> next cycle o_tvalid=0, i_tready=1; the next word emits from lane [23:16].

Source files
------------

// File: rtl/iq_nibble_pkg.sv
// Shared constants and types for the 4-bit IQ nibble unpacker.
// Lane order and expansion geometry must stay in step with the transmit-side packer.
package iq_nibble_pkg;

    localparam int NSUB        = 4;
    localparam int NIB_W       = 4;
    localparam int BYTE_W      = 2 * NIB_W;
    localparam int SAMPLE_W    = 16;
    localparam int DISCARD_LSB = 9;

    localparam logic [SAMPLE_W-1:0] ROUND_OFS = 16'h0100;

    // Bit offset of each symbol byte inside the packed word, in emission order.
    localparam int LANE_LSB [0:NSUB-1] = '{16, 24, 0, 8};

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

endpackage

// File: rtl/iq_nibble_expand.sv
// Combinational expansion of one packed {I nibble, Q nibble} byte into a {I16, Q16} sample.
// Optional mid-point rounding of the discarded LSBs: define IQ_UNPACK_ROUND_MID_EN.
module iq_nibble_expand
    import iq_nibble_pkg::*;
(
    input  logic [BYTE_W-1:0]     sym,
    output logic [2*SAMPLE_W-1:0] sample
);

    // The nibble's MSB is the sign; the three magnitude bits land just above the discarded LSBs.
    function automatic logic [SAMPLE_W-1:0] expand_nib(input logic [NIB_W-1:0] nib);
        logic [SAMPLE_W-1:0] v;
        v = {{4{nib[NIB_W-1]}}, nib[NIB_W-2:0], {DISCARD_LSB{1'b0}}};
`ifdef IQ_UNPACK_ROUND_MID_EN
        v = v + ROUND_OFS;
`endif
        return v;
    endfunction

    always_comb begin
        sample = {expand_nib(sym[BYTE_W-1:NIB_W]), expand_nib(sym[NIB_W-1:0])};
    end

endmodule

// File: rtl/iq_nibble_unpack.sv
// Unpacks one 32-bit word of four nibble-pair symbols into four {I16,Q16} samples, AXI-Stream both sides.
// Build option IQ_UNPACK_ROUND_MID_EN (inside iq_nibble_expand) adds mid-point rounding.
module iq_nibble_unpack
    import iq_nibble_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready
);

    if (WIDTH != 32) begin : g_width_check
        $error("iq_nibble_unpack: only WIDTH=32 is supported");
    end

    state_t                 state;
    state_t                 state_nxt;
    logic [1:0]             sub_cnt;
    logic [WIDTH-1:0]       hold_word;
    logic                   hold_last;
    logic                   last_sub;
    logic                   in_fire;
    logic                   out_fire;
    logic [BYTE_W-1:0]      lane_byte;
    logic [2*SAMPLE_W-1:0]  lane_sample;

    assign last_sub = (sub_cnt == 2'(NSUB - 1));
    assign in_fire  = i_tvalid & i_tready;
    assign out_fire = o_tvalid & o_tready;

    always_comb begin
        lane_byte = hold_word[LANE_LSB[sub_cnt] +: BYTE_W];
    end

    iq_nibble_expand u_expand (
        .sym    (lane_byte),
        .sample (lane_sample)
    );

    // A new word always restarts the lane counter, even when it loads on the last sample's cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sub_cnt   <= '0;
            hold_word <= '0;
            hold_last <= 1'b0;
        end else begin
            state <= state_nxt;
            if (in_fire) begin
                hold_word <= i_tdata;
                hold_last <= i_tlast;
                sub_cnt   <= '0;
            end else if (out_fire) begin
                sub_cnt <= sub_cnt + 2'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_tvalid) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (out_fire && last_sub && !i_tvalid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Input is only accepted in EMIT when the final sample leaves this cycle, so nothing is overwritten.
    always_comb begin
        i_tready = 1'b0;
        o_tvalid = 1'b0;
        o_tdata  = '0;
        o_tlast  = 1'b0;
        case (state)
            IDLE: begin
                i_tready = 1'b1;
            end
            EMIT: begin
                o_tvalid = 1'b1;
                o_tdata  = lane_sample;
                o_tlast  = hold_last & last_sub;
                i_tready = last_sub & o_tready;
            end
            default: begin
                i_tready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_iq_nibble_unpack.sv
// Scoreboard testbench for iq_nibble_unpack; expected samples are queued when words are driven.
// Build with IQ_UNPACK_ROUND_MID_EN defined to check the rounded variant.
module tb_iq_nibble_unpack;

    localparam int TIMEOUT = 200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] i_tdata = '0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready = 1'b0;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   n_compared = 0;
    int   n_mismatched = 0;

    always #5 clk = ~clk;

    iq_nibble_unpack #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_tdata  (i_tdata),
        .i_tlast  (i_tlast),
        .i_tvalid (i_tvalid),
        .i_tready (i_tready),
        .o_tdata  (o_tdata),
        .o_tlast  (o_tlast),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready)
    );

    // Reference: nibble is a 4-bit two's-complement value scaled by 512.
    function automatic logic [15:0] nib_model(input logic [3:0] n);
        int v;
        logic [31:0] t;
        v = n[3] ? int'(n) - 16 : int'(n);
        v = v * 512;
`ifdef IQ_UNPACK_ROUND_MID_EN
        v = v + 256;
`endif
        t = v;
        return t[15:0];
    endfunction

    function automatic logic [31:0] sample_model(input logic [31:0] w, input int idx);
        int lanes [4] = '{16, 24, 0, 8};
        logic [31:0] sh;
        sh = w >> lanes[idx];
        return {nib_model(sh[7:4]), nib_model(sh[3:0])};
    endfunction

    task automatic applyStimulus(input logic [31:0] w, input logic last);
        int cyc;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{data: sample_model(w, i), last: (last && i == 3)});
        end
        i_tdata  = w;
        i_tlast  = last;
        i_tvalid = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!i_tready && cyc < TIMEOUT) begin
            @(negedge clk);
            cyc++;
        end
        if (!i_tready) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL accept_timeout: i_tready=%b required 1 for word %h", i_tready, w);
        end
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_compared++;
        if (o_tvalid !== 1'b0 || o_tlast !== 1'b0 || o_tdata !== 32'h0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_outputs: got valid=%b last=%b data=%h required 0/0/00000000", o_tvalid, o_tlast, o_tdata);
        end
        n_compared++;
        if (i_tready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL reset_ready: got %b required 1", i_tready);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_compared++;
        if (o_tvalid !== 1'b0 || i_tready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL post_reset_idle: got valid=%b ready=%b required 0/1", o_tvalid, i_tready);
        end
    endtask

    task automatic test_known_word();
        logic [31:0] known [4];
        exp_t e;
`ifdef IQ_UNPACK_ROUND_MID_EN
        known = '{32'h07000900, 32'h03000500, 32'h0F00F100, 32'h0B000D00};
`else
        known = '{32'h06000800, 32'h02000400, 32'h0E00F000, 32'h0A000C00};
`endif
        @(posedge clk);
        #1;
        o_tready = 1'b1;
        applyStimulus(32'h12345678, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_compared++;
            if (o_tvalid !== 1'b1 || o_tdata !== known[k] || o_tdata !== e.data || o_tlast !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL known_word[%0d]: got valid=%b data=%h last=%b required 1/%h/0", k, o_tvalid, o_tdata, o_tlast, known[k]);
            end
        end
        @(negedge clk);
        n_compared++;
        if (o_tvalid !== 1'b0 || i_tready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL known_word_drain: got valid=%b ready=%b required 0/1", o_tvalid, i_tready);
        end
    endtask

    task automatic test_full_scale();
        logic [31:0] words [2];
        logic [31:0] lits [2];
        exp_t e;
        words = '{32'hFFFFFFFF, 32'h88888888};
`ifdef IQ_UNPACK_ROUND_MID_EN
        lits = '{32'hFF00FF00, 32'hF100F100};
`else
        lits = '{32'hFE00FE00, 32'hF000F000};
`endif
        @(posedge clk);
        #1;
        o_tready = 1'b1;
        for (int w = 0; w < 2; w++) begin
            applyStimulus(words[w], 1'b1);
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                e = sb.pop_front();
                n_compared++;
                if (o_tvalid !== 1'b1 || o_tdata !== lits[w] || o_tdata !== e.data || o_tlast !== (k == 3)) begin
                    n_mismatched++;
                    $display("[TB] FAIL full_scale %h[%0d]: got valid=%b data=%h last=%b required 1/%h/%b", words[w], k, o_tvalid, o_tdata, o_tlast, lits[w], (k == 3));
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk);
        #1;
        o_tready = 1'b1;
        fork
            begin
                applyStimulus(32'hC3A51E7F, 1'b0);
                applyStimulus(32'h0F1E2D3C, 1'b1);
            end
            begin
                int cyc;
                exp_t e;
                cyc = 0;
                @(negedge clk);
                while (!o_tvalid && cyc < TIMEOUT) begin
                    @(negedge clk);
                    cyc++;
                end
                for (int k = 0; k < 8; k++) begin
                    n_compared++;
                    if (o_tvalid !== 1'b1 || i_tready !== (k % 4 == 3)) begin
                        n_mismatched++;
                        $display("[TB] FAIL b2b_flow[%0d]: got valid=%b ready=%b required 1/%b", k, o_tvalid, i_tready, (k % 4 == 3));
                    end
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        n_compared++;
                        if (o_tdata !== e.data || o_tlast !== e.last) begin
                            n_mismatched++;
                            $display("[TB] FAIL b2b_data[%0d]: got %h/%b required %h/%b", k, o_tdata, o_tlast, e.data, e.last);
                        end
                    end
                    @(negedge clk);
                end
                n_compared++;
                if (o_tvalid !== 1'b0) begin
                    n_mismatched++;
                    $display("[TB] FAIL b2b_end: got valid=%b required 0", o_tvalid);
                end
            end
        join
    endtask

    task automatic test_random_backpressure();
        @(posedge clk);
        #1;
        fork
            begin
                for (int w = 0; w < 64; w++) begin
                    applyStimulus($urandom, (w % 8 == 7));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
            begin
                logic        stalled = 1'b0;
                logic [31:0] stall_data = '0;
                logic        stall_last = 1'b0;
                exp_t        e;
                for (int s = 0; s < 256; s++) begin
                    int cyc = 0;
                    logic got = 1'b0;
                    while (!got && cyc < TIMEOUT) begin
                        @(posedge clk);
                        #1;
                        o_tready = 1'($urandom_range(0, 1));
                        @(negedge clk);
                        if (stalled) begin
                            n_compared++;
                            if (o_tvalid !== 1'b1 || o_tdata !== stall_data || o_tlast !== stall_last) begin
                                n_mismatched++;
                                $display("[TB] FAIL stall_hold: got %b/%h/%b required 1/%h/%b", o_tvalid, o_tdata, o_tlast, stall_data, stall_last);
                            end
                        end
                        stalled    = o_tvalid && !o_tready;
                        stall_data = o_tdata;
                        stall_last = o_tlast;
                        if (o_tvalid && o_tready) begin
                            got = 1'b1;
                            n_compared++;
                            if (sb.size() == 0) begin
                                n_mismatched++;
                                $display("[TB] FAIL rand_extra: got unexpected sample %h required none", o_tdata);
                            end else begin
                                e = sb.pop_front();
                                if (o_tdata !== e.data || o_tlast !== e.last) begin
                                    n_mismatched++;
                                    $display("[TB] FAIL rand_sample[%0d]: got %h/%b required %h/%b", s, o_tdata, o_tlast, e.data, e.last);
                                end
                            end
                        end
                        cyc++;
                    end
                    if (!got) begin
                        n_compared++;
                        n_mismatched++;
                        $display("[TB] FAIL rand_timeout[%0d]: got no sample required one", s);
                    end
                end
            end
        join
        n_compared++;
        if (sb.size() != 0) begin
            n_mismatched++;
            $display("[TB] FAIL rand_leftover: got %0d pending required 0", sb.size());
        end
        o_tready = 1'b1;
    endtask

    task automatic test_reset_midword();
        exp_t e;
        @(posedge clk);
        #1;
        o_tready = 1'b1;
        applyStimulus(32'h12345678, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_compared++;
            if (o_tvalid !== 1'b1 || o_tdata !== e.data) begin
                n_mismatched++;
                $display("[TB] FAIL pre_reset[%0d]: got %b/%h required 1/%h", k, o_tvalid, o_tdata, e.data);
            end
        end
        @(posedge clk);
        #1;
        o_tready = 1'b0;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        n_compared++;
        if (o_tvalid !== 1'b0 || i_tready !== 1'b1 || o_tlast !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL midword_reset: got valid=%b ready=%b last=%b required 0/1/0", o_tvalid, i_tready, o_tlast);
        end
        @(posedge clk);
        #1;
        o_tready = 1'b1;
        applyStimulus(32'hA1B2C3D4, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e = sb.pop_front();
            n_compared++;
            if (o_tvalid !== 1'b1 || o_tdata !== e.data || o_tlast !== e.last) begin
                n_mismatched++;
                $display("[TB] FAIL post_reset_word[%0d]: got %b/%h/%b required 1/%h/%b", k, o_tvalid, o_tdata, o_tlast, e.data, e.last);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_known_word();
        test_full_scale();
        test_back_to_back();
        test_random_backpressure();
        test_reset_midword();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
